// File: rtl/mod_counter_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter_chain_if
//  Description : Control/status bundle for the modulo counter chain. The
//                master side drives the count controls and preset; the slave
//                side (the counter) returns the count, chain carry and
//                sticky wrap flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_counter_chain_if #(
    parameter int DIGITS = 4,
    parameter int DW     = 4
);
    logic                   en;
    logic                   up_dn;
    logic                   clr;
    logic                   load;
    logic [DIGITS*DW-1:0]   load_val;
    logic [DIGITS*DW-1:0]   cnt;
    logic                   cout;
    logic                   ovf;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  cnt, cout, ovf
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output cnt, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mod_counter_chain.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter_chain
//  Description : Cascade of DIGITS modulo-RADIX digits counting up or down,
//                with clear > load > enable priority, combinational chain
//                carry/borrow (cout) and a sticky wrap flag (ovf).
//                Optional macro MODCNT_SATURATE_EN: a full-chain wrap is
//                suppressed and the count holds at the terminal value
//                (ovf still sets, cout still reports terminal).
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter_chain #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10,
    parameter int DW     = 4
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    mod_counter_chain_if.slave  bus
);
    localparam logic [DW-1:0] c_MAX     = DW'(RADIX - 1);
    localparam logic [DW:0]   c_RADIX_W = (DW+1)'(RADIX);

    logic [DIGITS*DW-1:0] cnt_q;
    logic [DIGITS*DW-1:0] cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic [DIGITS*DW-1:0] w_step_val;
    logic [DIGITS*DW-1:0] w_load_san;
    logic                 w_all_max;
    logic                 w_all_zero;
    logic                 w_term;
    logic [DW-1:0]        w_dig;
    logic [DW-1:0]        w_fld;

    // Per-digit step and load sanitising; a digit steps only when every lower digit sits at its wrap point
    always_comb begin
        w_step_val = cnt_q;
        w_load_san = '0;
        w_all_max  = 1'b1;
        w_all_zero = 1'b1;
        w_dig      = '0;
        w_fld      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = cnt_q[i*DW +: DW];
            w_fld = bus.load_val[i*DW +: DW];
            if (bus.up_dn && w_all_max) begin
                w_step_val[i*DW +: DW] = (w_dig == c_MAX) ? '0 : w_dig + DW'(1);
            end
            if (!bus.up_dn && w_all_zero) begin
                w_step_val[i*DW +: DW] = (w_dig == '0) ? c_MAX : w_dig - DW'(1);
            end
            w_load_san[i*DW +: DW] = ({1'b0, w_fld} < c_RADIX_W) ? w_fld : '0;
            w_all_max  = w_all_max  & (w_dig == c_MAX);
            w_all_zero = w_all_zero & (w_dig == '0);
        end
    end

    // Terminal state depends on the current direction only; no direction is stored
    assign w_term   = bus.up_dn ? w_all_max : w_all_zero;
    assign bus.cout = bus.en & w_term & ~bus.clr & ~bus.load;

    // Next-state selection with clr > load > en priority
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            cnt_d = w_load_san;
        end else if (bus.en) begin
            if (w_term) begin
                ovf_d = 1'b1;
            end
`ifdef MODCNT_SATURATE_EN
            // A full-chain wrap is suppressed, so lower digits also hold
            if (!w_term) begin
                cnt_d = w_step_val;
            end
`else
            cnt_d = w_step_val;
`endif
        end
    end

    // State registers; reset clears count and flag immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.cnt = cnt_q;
    assign bus.ovf = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_mod_counter_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_counter_chain
//  Description : Scoreboard bench for mod_counter_chain (DIGITS=2, RADIX=10).
//                The reference model keeps the count as a plain integer
//                modulo RADIX**DIGITS.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter_chain;
    localparam int DIGITS = 2;
    localparam int RADIX  = 10;
    localparam int DW     = 4;
    localparam int NMOD   = RADIX ** DIGITS;

    typedef struct {
        logic                 cout;
        logic [DIGITS*DW-1:0] cnt;
        logic                 ovf;
        int                   tag;
    } exp_t;

    logic clk;
    logic rstn;
    exp_t q[$];
    int   n_cmp;
    int   n_bad;
    int   m_val;
    bit   m_ovf;
    int   n_step;

    mod_counter_chain_if #(.DIGITS(DIGITS), .DW(DW)) bus ();

    mod_counter_chain #(.DIGITS(DIGITS), .RADIX(RADIX), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DIGITS*DW-1:0] enc(input int v);
        logic [DIGITS*DW-1:0] r;
        int pw;
        r  = '0;
        pw = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*DW +: DW] = DW'((v / pw) % RADIX);
            pw = pw * RADIX;
        end
        return r;
    endfunction

    function automatic int dec(input logic [DIGITS*DW-1:0] lv);
        int v;
        int pw;
        int f;
        v  = 0;
        pw = 1;
        for (int i = 0; i < DIGITS; i++) begin
            f = int'(lv[i*DW +: DW]);
            if (f < RADIX) v = v + f * pw;
            pw = pw * RADIX;
        end
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; model result for this edge goes to the scoreboard
    task automatic step(input bit en, input bit up, input bit clr, input bit ld,
                        input logic [DIGITS*DW-1:0] lv);
        exp_t e;
        bit   term;
        @(negedge clk);
        bus.en       = en;
        bus.up_dn    = up;
        bus.clr      = clr;
        bus.load     = ld;
        bus.load_val = lv;
        term   = up ? (m_val == NMOD - 1) : (m_val == 0);
        e.cout = en && !clr && !ld && term;
        if (clr) begin
            m_val = 0;
            m_ovf = 1'b0;
        end else if (ld) begin
            m_val = dec(lv);
        end else if (en) begin
            if (term) begin
                m_ovf = 1'b1;
`ifndef MODCNT_SATURATE_EN
                m_val = up ? 0 : NMOD - 1;
`endif
            end else begin
                m_val = up ? m_val + 1 : m_val - 1;
            end
        end
        e.cnt  = enc(m_val);
        e.ovf  = m_ovf;
        n_step = n_step + 1;
        e.tag  = n_step;
        q.push_back(e);
    endtask

    // Monitor: cout sampled mid-cycle, cnt/ovf sampled just after the edge
    initial begin : mon
        logic s_cout;
        exp_t e;
        forever begin
            @(negedge clk);
            #1 s_cout = bus.cout;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("cout step%0d", e.tag), int'(s_cout), int'(e.cout));
                check($sformatf("cnt step%0d", e.tag), int'(bus.cnt), int'(e.cnt));
                check($sformatf("ovf step%0d", e.tag), int'(bus.ovf), int'(e.ovf));
            end
        end
    end

    initial begin : main
        n_cmp  = 0;
        n_bad  = 0;
        n_step = 0;
        m_val  = 0;
        m_ovf  = 1'b0;
        bus.en = 1'b0; bus.up_dn = 1'b1; bus.clr = 1'b0; bus.load = 1'b0;
        bus.load_val = '0;
        rstn = 1'b0;
        #2;
        check("reset cnt", int'(bus.cnt), 0);
        check("reset ovf", int'(bus.ovf), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Full up sweep 00..99 then wrap
        for (int i = 0; i < NMOD; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

        // Load sanitising: high field 0xC loads as 0, load beats en, ovf kept
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hC7);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Down wrap from 00
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Priority: clr over load over en with cnt=55
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h12);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0, 8'($urandom));
        end

        // Asynchronous reset mid-cycle with cnt=37 and a pending load
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h37);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        bus.load_val = 8'h55;
        bus.load     = 1'b1;
        bus.en       = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("midreset cnt", int'(bus.cnt), 0);
        check("midreset ovf", int'(bus.ovf), 0);
        @(posedge clk);
        #1;
        check("inreset cnt", int'(bus.cnt), 0);
        @(negedge clk);
        bus.load = 1'b0;
        bus.en   = 1'b0;
        rstn     = 1'b1;
        m_val    = 0;
        m_ovf    = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("scoreboard drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mod_counter_chain.md
Name: mod_counter_chain

Overview:
- Parametrised cascade of DIGITS modulo-RADIX counter digits (default: 4-digit decimal), counting up or down.
- Supports count enable, synchronous clear, synchronous parallel load, a chain carry/borrow output and a sticky overflow flag.
- Successor to the single-digit decade counter, used for timers, display counters and event tallies.
- Multiple instances cascade by tying one instance's cout to the next instance's en.

Parameters:
- DIGITS, 4, number of cascaded digits (1..8).
- RADIX, 10, modulus of every digit (2..2**DW).
- DW, 4, bit width of one digit field.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous reset, active low.
- en  input  1  count enable: one step per clock while high.
- up_dn  input  1  direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear to all zeros.
- load  input  1  synchronous parallel load from load_val.
- load_val  input  DIGITS*DW  preset value; digit i is at bits [i*DW +: DW]; digit 0 is least significant.
- cnt  output  DIGITS*DW  current count, same packing as load_val.
- cout  output  1  chain carry/borrow, combinational.
- ovf  output  1  sticky wrap flag, registered.

Behaviour:
- Reset (rstn low, asynchronous):
  - cnt = 0 and ovf = 0 immediately, regardless of clk.
  - Release is synchronous in effect: the first count can occur on the first rising edge after rstn goes high.
- Per-edge priority: clr > load > en.
  - clr: cnt <= 0; ovf <= 0.
  - load: each digit <= its load_val field; a field with value >= RADIX loads as 0. ovf is unchanged.
  - en and neither clr nor load: the chain steps once.
  - None asserted: hold all state.
- Up step:
  - Digit 0 increments.
  - Digit i (i>0) increments only when every lower digit equals RADIX-1.
  - A digit at RADIX-1 that steps wraps to 0.
- Down step:
  - Digit 0 decrements.
  - Digit i decrements only when every lower digit equals 0.
  - A digit at 0 that steps wraps to RADIX-1.
- Terminal state: all digits at RADIX-1 when up_dn=1; all digits at 0 when up_dn=0.
- cout = en & (cnt is in the terminal state for the current up_dn) & ~clr & ~load.
  - cout is high during the cycle before a full-chain wrap, which matches the single-digit cout semantics.
- ovf is set on the edge where a full-chain wrap occurs, and stays set until clr or reset.
- Direction change takes effect at the next edge; there is no internal direction state.
- Latency:
  - cnt updates on the same edge that samples en, clr or load.
  - ovf updates on the same edge as the wrap.
- Arithmetic:
  - Per-digit compare and wrap only; there is no binary adder across digit boundaries.
  - Digit fields never hold values >= RADIX.
- Reset asserted mid-count: immediate return to zero, and any pending load is discarded.

Optional Feature:
- Macro: MODCNT_SATURATE_EN.
- Defined:
  - A step that would wrap the full chain is suppressed: cnt holds the terminal value.
  - ovf is still set on the suppressed step.
  - cout still reports the terminal state.
  - Lower digits do not wrap while the chain holds.
- Undefined: full-chain wrap-around as described in Behaviour.

Test Plan:
- DIGITS=2, RADIX=10:
  - Reset: rstn low mid-cycle with cnt=37 -> cnt=0 and ovf=0 without a clock edge.
  - Up count: en=1, up_dn=1 from 0 for 100 cycles -> cnt steps 0..99 with correct digit carries (09->10, 19->20); cout high only while cnt=99; after the 100th edge cnt=00 and ovf=1.
  - Down count: load 00 then en=1, up_dn=0 -> next edge cnt=99 and ovf=1; cout was high during the cycle when cnt=00.
- Load sanitising: load with load_val fields {0xC, 0x7} and en=1 on the same edge -> cnt=07, load wins over en, ovf unchanged.
- Priority: clr=1, load=1 and en=1 together with cnt=55 -> cnt=00, ovf=0, cout=0.
- Saturation: MODCNT_SATURATE_EN defined, RADIX=16, DIGITS=1, cnt=15, up_dn=1, en=1 for 3 cycles -> cnt stays 15, ovf=1, cout=1 throughout.
